abr_masked_mult_arb: RTL
========================

Name: abr_masked_mult_arb

Overview:
- Round-robin arbiter and sequencer that shares one masked N-bit multiplier between NREQ requesters.
- The multiplier takes WIDTH-bit two-share operand x and WIDTH/2-bit public y, and has one-cycle latency.
- The block picks one requester per cycle, registers its operands into the multiplier and tracks the in-flight tag.
- It returns each two-share product to the requester that issued it. Sustained throughput is one product per clock.

Parameters:
- NREQ, 2, number of requesters; must be at least 2.
- WIDTH, 8, share width of x and z.
- HALF_WIDTH, WIDTH/2, width of public operand y.
- MULT_LAT, 1, multiplier latency in cycles. It sets the tag pipeline depth.
- IDW, $clog2(NREQ), requester-id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state and in-flight data
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_x  in  [NREQ][WIDTH][1:0]  per-requester two-share x
- req_y  in  [NREQ][HALF_WIDTH]  per-requester public y
- mult_x  out  [WIDTH][1:0]  registered shares to the multiplier
- mult_y  out  HALF_WIDTH  registered y to the multiplier
- mult_z  in  [WIDTH][1:0]  multiplier product shares
- rsp_valid  out  NREQ  one-hot response strobe
- rsp_id  out  IDW  id of the responding requester
- rsp_z  out  [WIDTH][1:0]  product shares; 0 when rsp_valid is 0
- busy  out  1  at least one operation is in flight

Behaviour:
- Reset (rst_n low, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, mult_x=0, mult_y=0, busy=0.
  - Round-robin pointer=0; tag pipeline cleared.
- Arbitration:
  - grant = first requester with req_valid set, searching from the pointer upward and wrapping at NREQ-1 to 0.
  - req_ready = grant, combinational from req_valid. It is forced to 0 while rst_n is low and in any cycle where zeroize=1.
  - Handshake completes when req_valid&req_ready. The requester must hold req_x and req_y stable until the handshake.
  - After a handshake, pointer = granted index + 1 (mod NREQ). With no handshake, the pointer holds.
- Operand stage, handshake at cycle t:
  - mult_x and mult_y load the granted operands at edge t+1.
  - Cycles with no handshake load mult_x=0 and mult_y=0, so no stale share stays on the bus.
  - Shares are muxed with the same one-hot select and never recombined or XOR-ed with each other.
- Tag pipeline:
  - {valid, id} shifts through MULT_LAT+1 registers.
  - A handshake at cycle t gives rsp_valid[id]=1 and rsp_id=id in cycle t+1+MULT_LAT, which is t+2 by default.
  - rsp_z = mult_z, gated to 0 when there is no response.
- No backpressure on responses: the requester must sink rsp_valid in that cycle.
- busy = OR of all tag-pipeline valid bits.
- Back-to-back handshakes every cycle give one response every cycle, in issue order.
- Zeroize (synchronous, priority over everything else):
  - Clears mult_x, mult_y, the tag pipeline, rsp_* outputs and the pointer.
  - In-flight results are dropped with no response, and no handshake is taken that cycle.
- Mid-operation reset behaves the same as zeroize, but is asynchronous.
- Arithmetic is performed only by the multiplier: each share is multiplied by y mod 2^WIDTH.
- Single requester active: it is granted every cycle.
- All valid: strict rotation 0,1,…,NREQ-1,0.

Optional Feature:
- Macro ABR_MULT_ARB_LOCK_EN.
- With it, an extra input req_lock[NREQ] is present.
  - A requester that completes a handshake with req_lock set keeps exclusive grant. Other requesters see req_ready=0 until it handshakes with req_lock=0 or drops req_valid.
  - The pointer advances only when the lock is released.
  - Used to hold the multiplier for a multi-word burst.
  - Zeroize clears the lock.
- Without it, the port is absent and arbitration is pure round-robin.

Decomposition:
- Shared package abr_masked_mult_pkg holds:
  - typedef share_vec_t, a [WIDTH][1:0] logic array;
  - typedef mult_tag_t struct {valid, id};
  - localparam ABR_MULT_LAT_DEFAULT=1.
- One sub-module is natural: abr_rr_arb, a parameterised NREQ round-robin grant picker.
  - Inputs: req, pointer, advance.
  - Output: one-hot grant.
  - It is reusable for other shared masked units.

Test Plan (WIDTH=8, NREQ=2):
- Single request: req0 with x shares 0x13/0x22 and y=0x5, multiplier model attached → req_ready[0] in the same cycle; rsp_valid[0] two cycles later with rsp_z shares 0x5F/0xAA and rsp_id=0.
- Contention: both requesters valid for 6 cycles → grants 0,1,0,1,0,1; responses in the same order at +2; throughput 1/clk; busy high throughout.
- Idle scrubbing: one handshake followed by no requests → mult_x=0 and mult_y=0 on the next edge; rsp_z=0 whenever rsp_valid=0.
- Zeroize with 2 ops in flight → no rsp_valid afterwards; pointer=0; busy=0 next cycle; req_ready=0 during the zeroize cycle.
- Async reset asserted mid-burst → all outputs 0 immediately. After release, req1 alone is granted first and its response is correct.
- With ABR_MULT_ARB_LOCK_EN: req0 locks for 3 handshakes while req1 is valid → req1 is held off; req1 is granted in the cycle after req0 releases the lock.

Source files
------------

// File: rtl/abr_masked_mult_pkg.sv
// Shared types for the masked-multiplier arbiter: two-share vectors, tag pipeline entries.
package abr_masked_mult_pkg;

    localparam int unsigned ABR_MULT_LAT_DEFAULT = 1;
    localparam int unsigned ABR_MULT_WIDTH       = 8;
    localparam int unsigned ABR_MULT_ID_MAX_W    = 8;

    // Bit-major share layout: v[bit][share]
    typedef logic [ABR_MULT_WIDTH-1:0][1:0] share_vec_t;

    typedef struct packed {
        logic                         valid;
        logic [ABR_MULT_ID_MAX_W-1:0] id;
    } mult_tag_t;

    function automatic logic [ABR_MULT_WIDTH-1:0] share_get(share_vec_t v, logic s);
        logic [ABR_MULT_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ABR_MULT_WIDTH; i++) r[i] = v[i][s];
        return r;
    endfunction

    function automatic share_vec_t share_pack(logic [ABR_MULT_WIDTH-1:0] s0,
                                              logic [ABR_MULT_WIDTH-1:0] s1);
        share_vec_t v;
        for (int unsigned i = 0; i < ABR_MULT_WIDTH; i++) begin
            v[i][0] = s0[i];
            v[i][1] = s1[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/abr_masked_mult_arb_if.sv
// Requester / multiplier / response bundle of the masked multiplier arbiter.
// req_lock exists only when ABR_MULT_ARB_LOCK_EN is defined.
interface abr_masked_mult_arb_if #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned HALF_WIDTH = WIDTH / 2,
    parameter int unsigned IDW        = $clog2(NREQ)
);
    logic [NREQ-1:0]                  req_valid;
    logic [NREQ-1:0]                  req_ready;
    logic [NREQ-1:0][WIDTH-1:0][1:0]  req_x;
    logic [NREQ-1:0][HALF_WIDTH-1:0]  req_y;
`ifdef ABR_MULT_ARB_LOCK_EN
    logic [NREQ-1:0]                  req_lock;
`endif
    logic [WIDTH-1:0][1:0]            mult_x;
    logic [HALF_WIDTH-1:0]            mult_y;
    logic [WIDTH-1:0][1:0]            mult_z;
    logic [NREQ-1:0]                  rsp_valid;
    logic [IDW-1:0]                   rsp_id;
    logic [WIDTH-1:0][1:0]            rsp_z;
    logic                             busy;

    // Requesters plus the multiplier side
    modport master (
        output req_valid, req_x, req_y, mult_z,
`ifdef ABR_MULT_ARB_LOCK_EN
        output req_lock,
`endif
        input  req_ready, mult_x, mult_y, rsp_valid, rsp_id, rsp_z, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, mult_z,
`ifdef ABR_MULT_ARB_LOCK_EN
        input  req_lock,
`endif
        output req_ready, mult_x, mult_y, rsp_valid, rsp_id, rsp_z, busy
    );
endinterface

// File: rtl/abr_masked_mult_arb_rr_arb.sv
// Round-robin one-hot grant picker; search starts at ptr and wraps at NREQ-1.
module abr_rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic [IDW-1:0]  ptr_next
);
    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Kept apart from the search so advance (derived from grant) forms no loop
    assign ptr_next = !advance                        ? ptr :
                      (grant_idx == IDW'(NREQ - 1))   ? '0  :
                                                        grant_idx + IDW'(1);
endmodule

// File: rtl/abr_masked_mult_arb.sv
// Shares one masked multiplier between NREQ requesters: round-robin issue, tag tracking,
// product return. Optional exclusive burst lock enabled by ABR_MULT_ARB_LOCK_EN.
module abr_masked_mult_arb
    import abr_masked_mult_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned HALF_WIDTH = WIDTH / 2,
    parameter int unsigned MULT_LAT   = ABR_MULT_LAT_DEFAULT,
    parameter int unsigned IDW        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  zeroize,
    abr_masked_mult_arb_if.slave  bus
);
    logic [NREQ-1:0]        arb_req_c;
    logic [NREQ-1:0]        grant_c;
    logic [IDW-1:0]         grant_idx_c;
    logic [IDW-1:0]         ptr_next_c;
    logic [IDW-1:0]         ptr_q;
    logic                   hs_c;
    logic                   advance_c;
    logic [WIDTH-1:0][1:0]  x_mux_c;
    logic [HALF_WIDTH-1:0]  y_mux_c;
    logic [WIDTH-1:0][1:0]  mult_x_q;
    logic [HALF_WIDTH-1:0]  mult_y_q;
    mult_tag_t [MULT_LAT:0] tag_q;
    logic                   rsp_fire_c;

`ifdef ABR_MULT_ARB_LOCK_EN
    logic           lock_q;
    logic [IDW-1:0] lock_id_q;
    logic           lock_hold_c;
    logic           lock_take_c;

    // A held lock narrows arbitration to its owner while the owner stays valid
    assign lock_hold_c = lock_q && bus.req_valid[lock_id_q];
    assign arb_req_c   = lock_hold_c ? (bus.req_valid & (NREQ'(1) << lock_id_q)) : bus.req_valid;
    assign lock_take_c = hs_c && bus.req_lock[grant_idx_c];
    assign advance_c   = hs_c && !lock_take_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (zeroize) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (hs_c) begin
            lock_q    <= lock_take_c;
            lock_id_q <= grant_idx_c;
        end else if (lock_q && !lock_hold_c) begin
            lock_q    <= 1'b0;
        end
    end
`else
    assign arb_req_c = bus.req_valid;
    assign advance_c = hs_c;
`endif

    abr_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req       (arb_req_c),
        .ptr       (ptr_q),
        .advance   (advance_c),
        .grant     (grant_c),
        .grant_idx (grant_idx_c),
        .ptr_next  (ptr_next_c)
    );

    assign bus.req_ready = (rst_n && !zeroize) ? grant_c : '0;
    assign hs_c          = |bus.req_ready;

    // One-hot AND-OR select; each share lane stays separate and is zero when idle
    always_comb begin
        x_mux_c = '0;
        y_mux_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            x_mux_c = x_mux_c | (bus.req_x[i] & {(2*WIDTH){bus.req_ready[i]}});
            y_mux_c = y_mux_c | (bus.req_y[i] & {HALF_WIDTH{bus.req_ready[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            mult_x_q <= '0;
            mult_y_q <= '0;
            tag_q    <= '0;
        end else if (zeroize) begin
            ptr_q    <= '0;
            mult_x_q <= '0;
            mult_y_q <= '0;
            tag_q    <= '0;
        end else begin
            ptr_q        <= ptr_next_c;
            mult_x_q     <= x_mux_c;
            mult_y_q     <= y_mux_c;
            tag_q[0].valid <= hs_c;
            tag_q[0].id    <= ABR_MULT_ID_MAX_W'(grant_idx_c);
            for (int unsigned k = 1; k <= MULT_LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign bus.mult_x = mult_x_q;
    assign bus.mult_y = mult_y_q;

    // Response decode from the last tag stage; a zeroize cycle drops it
    always_comb begin
        rsp_fire_c    = tag_q[MULT_LAT].valid && !zeroize;
        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            bus.rsp_valid[i] = rsp_fire_c && (tag_q[MULT_LAT].id == ABR_MULT_ID_MAX_W'(i));
        bus.rsp_id = rsp_fire_c ? IDW'(tag_q[MULT_LAT].id) : '0;
        bus.rsp_z  = rsp_fire_c ? bus.mult_z : '0;
        bus.busy   = 1'b0;
        for (int unsigned k = 0; k <= MULT_LAT; k++) bus.busy = bus.busy | tag_q[k].valid;
    end

endmodule
